// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control / hazard unit:
// opcode and funct encodings, ALU control codes, forward-select codes and
// the decoded control bundle carried through the pipeline registers.
package pipe_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // EX-stage operand forward selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Decoded control bundle; all-zero is a nop / bubble
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src_b;
    logic [2:0] alu_control;
    logic       branch;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit_if.sv
// Bundle between the control/hazard unit and the datapath.
// There is no valid/ready handshake on this bus: every signal is a
// level that is meaningful every cycle. The datapath (master) presents
// the ID-stage instruction and the EX-stage zero flag; the unit (slave)
// returns stage-aligned controls, forward selects, stall and flush.
interface pipe_ctrl_hazard_unit_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [31:0]           instrD;
  logic                  zeroE;
  logic                  regDst;
  logic                  aluSrcB;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic                  memWrite;
  logic                  mem2Reg;
  logic                  regWrite;
  logic                  pcSrc;
  logic [1:0]            fad;
  logic [1:0]            fbd;
  logic                  stall;
  logic                  flush;

  modport slave (
    input  instrD, zeroE,
    output regDst, aluSrcB, aluControl, memWrite, mem2Reg, regWrite,
           pcSrc, fad, fbd, stall, flush
  );

  modport master (
    output instrD, zeroE,
    input  regDst, aluSrcB, aluControl, memWrite, mem2Reg, regWrite,
           pcSrc, fad, fbd, stall, flush
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Purely combinational main decoder: opcode + funct -> control bundle.
// Unknown opcodes and unknown R-type functs decode to an all-zero nop.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  // Decode opcode, then funct for R-type; anything unrecognised is a nop
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          default: ctrl = '0;
        endcase
      end
      OP_LW: begin
        ctrl.alu_src_b   = 1'b1;
        ctrl.mem2reg     = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src_b   = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src_b   = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Pipeline control and hazard unit. Decodes the ID instruction, carries
// control through ID/EX, EX/MEM and MEM/WB, and produces forward selects,
// stall and flush, each aligned to the stage that consumes it.
// Build option: HAZ_FORWARD_EN -- when defined, EX operands are forwarded
// from MEM/WB and only load-use stalls; when undefined, forwarding is off
// and ID stalls on any pending EX/MEM register write it depends on.
module pipe_ctrl_hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_ctrl_hazard_unit_if.slave bus
);

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] write_reg;
  } idex_t;

  typedef struct packed {
    logic                  mem_write;
    logic                  mem2reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } exmem_t;

  typedef struct packed {
    logic                  mem2reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  ctrl_t                 ctrl_id;
  logic [REG_ADDR_W-1:0] rs_d;
  logic [REG_ADDR_W-1:0] rt_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  stall_raw;
  logic                  stall_c;
  logic                  flush_c;
  logic [1:0]            fad_c;
  logic [1:0]            fbd_c;
  logic                  unused_ok;

  assign rs_d = REG_ADDR_W'(bus.instrD[25:21]);
  assign rt_d = REG_ADDR_W'(bus.instrD[20:16]);
  assign rd_d = REG_ADDR_W'(bus.instrD[15:11]);

  ctrl_decoder u_ctrl_decoder (
    .op    (bus.instrD[31:26]),
    .funct (bus.instrD[5:0]),
    .ctrl  (ctrl_id)
  );

  // Forward select for one EX source register: MEM result beats WB result, $0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input exmem_t m, input memwb_t w);
    if (m.reg_write && m.write_reg != '0 && m.write_reg == src)
      return FWD_MEM;
    else if (w.reg_write && w.write_reg != '0 && w.write_reg == src)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  // Branch resolution, hazard detection and forwarding (all combinational)
  always_comb begin
    flush_c = idex_q.ctrl.branch & bus.zeroE;
`ifdef HAZ_FORWARD_EN
    stall_raw = idex_q.ctrl.mem2reg & idex_q.ctrl.reg_write &
                (idex_q.rt != '0) & ((idex_q.rt == rs_d) | (idex_q.rt == rt_d));
    fad_c     = fwd_sel(idex_q.rs, exmem_q, memwb_q);
    fbd_c     = fwd_sel(idex_q.rt, exmem_q, memwb_q);
`else
    // WB writes land in the first half-cycle, so only EX and MEM writers block ID
    stall_raw = ((rs_d != '0) &
                 ((idex_q.ctrl.reg_write & (idex_q.write_reg == rs_d)) |
                  (exmem_q.reg_write     & (exmem_q.write_reg == rs_d)))) |
                ((rt_d != '0) &
                 ((idex_q.ctrl.reg_write & (idex_q.write_reg == rt_d)) |
                  (exmem_q.reg_write     & (exmem_q.write_reg == rt_d))));
    fad_c     = FWD_REG;
    fbd_c     = FWD_REG;
`endif
    // A taken branch discards the ID instruction, so its stall is moot
    stall_c = stall_raw & ~flush_c;
  end

  // Next-state for the three control registers; ID/EX takes a bubble on stall or flush
  always_comb begin
    idex_d = '0;
    if (!(stall_c || flush_c)) begin
      idex_d.ctrl      = ctrl_id;
      idex_d.rs        = rs_d;
      idex_d.rt        = rt_d;
      idex_d.write_reg = ctrl_id.reg_dst ? rd_d : rt_d;
    end
    exmem_d.mem_write = idex_q.ctrl.mem_write;
    exmem_d.mem2reg   = idex_q.ctrl.mem2reg;
    exmem_d.reg_write = idex_q.ctrl.reg_write;
    exmem_d.write_reg = idex_q.write_reg;
    memwb_d.mem2reg   = exmem_q.mem2reg;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.write_reg = exmem_q.write_reg;
  end

  // Pipeline control registers; reset drops every in-flight control immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.regDst     = idex_q.ctrl.reg_dst;
  assign bus.aluSrcB    = idex_q.ctrl.alu_src_b;
  assign bus.aluControl = ALU_CTRL_W'(idex_q.ctrl.alu_control);
  assign bus.memWrite   = exmem_q.mem_write;
  assign bus.mem2Reg    = memwb_q.mem2reg;
  assign bus.regWrite   = memwb_q.reg_write;
  assign bus.pcSrc      = flush_c;
  assign bus.flush      = flush_c;
  assign bus.stall      = stall_c;
  assign bus.fad        = fad_c;
  assign bus.fbd        = fbd_c;

  // Shamt is never needed; register fields are only read when forwarding is built in
  assign unused_ok = ^{bus.instrD[10:6], idex_q.rs, idex_q.rt, memwb_q.write_reg};

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed, table-driven bench for pipe_ctrl_hazard_unit. The expected
// table follows the build option HAZ_FORWARD_EN so both builds are covered.
module tb_pipe_ctrl_hazard_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_hazard_unit_if #(.ALU_CTRL_W(3)) bus ();

  pipe_ctrl_hazard_unit #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- types / scoreboard ----------------
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src_b;
    logic [2:0] alu_control;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_write;
    logic       pc_src;
    logic       flush;
    logic       stall;
    logic [1:0] fad;
    logic [1:0] fbd;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    out_t        exp;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;
  localparam logic [2:0] A_0   = 3'b000;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // ex(regDst, aluSrcB, aluControl, memWrite, mem2Reg, regWrite, pcSrc, stall, fad, fbd); flush = pcSrc
  function automatic out_t ex(input bit rd, input bit as, input logic [2:0] alu,
                              input bit mw, input bit m2r, input bit rw, input bit pc,
                              input bit st, input logic [1:0] fa, input logic [1:0] fb);
    out_t o;
    o.reg_dst = rd; o.alu_src_b = as; o.alu_control = alu;
    o.mem_write = mw; o.mem2reg = m2r; o.reg_write = rw;
    o.pc_src = pc; o.flush = pc; o.stall = st; o.fad = fa; o.fbd = fb;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.reg_dst = bus.regDst; o.alu_src_b = bus.aluSrcB; o.alu_control = bus.aluControl;
    o.mem_write = bus.memWrite; o.mem2reg = bus.mem2Reg; o.reg_write = bus.regWrite;
    o.pc_src = bus.pcSrc; o.flush = bus.flush; o.stall = bus.stall;
    o.fad = bus.fad; o.fbd = bus.fbd;
    return o;
  endfunction

  task automatic check(input string name, input int idx, input out_t e);
    logic [14:0] got;
    logic [14:0] want;
    exp_q.push_back(e);
    got  = sample();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] got=%015b want=%015b (rd,as,alu3,mw,m2r,rw,pc,fl,st,fa2,fb2)",
               name, idx, got, want);
    end
  endtask

  // ---------------- driver ----------------
  task automatic add(input logic [31:0] i, input logic z, input out_t e);
    vec_t v;
    v.instr = i; v.zero = z; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.instrD = v.instr;
    bus.zeroE  = v.zero;
    @(negedge clk);
    check("vec", idx, v.exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] nop_i, add_i, sub_i, add0_i, sub0_i, lw_i, add2_i, beq_i, sw_i, slt_i;
    logic [31:0] subb_i, addi3_i;
    out_t z;
    z       = '0;
    nop_i   = 32'h0;
    add_i   = r_type(1, 2, 3, 6'h20);       // add $3,$1,$2
    sub_i   = r_type(3, 5, 4, 6'h22);       // sub $4,$3,$5
    add0_i  = r_type(1, 2, 0, 6'h20);       // add $0,$1,$2
    sub0_i  = r_type(0, 5, 4, 6'h22);       // sub $4,$0,$5
    lw_i    = i_type(6'h23, 1, 2, 16'h0);   // lw $2,0($1)
    add2_i  = r_type(2, 2, 4, 6'h20);       // add $4,$2,$2
    beq_i   = i_type(6'h04, 1, 1, 16'h3);   // beq $1,$1
    sw_i    = i_type(6'h2B, 1, 2, 16'h4);   // sw $2,4($1)
    slt_i   = r_type(1, 2, 6, 6'h2A);       // slt $6,$1,$2
    subb_i  = r_type(5, 3, 4, 6'h22);       // sub $4,$5,$3
    addi3_i = i_type(6'h08, 3, 3, 16'h1);   // addi $3,$3,1

    bus.instrD = nop_i;
    bus.zeroE  = 1'b0;

`ifdef HAZ_FORWARD_EN
    add(nop_i, 0, z);
    add(add_i, 0, z);
    add(sub_i, 0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_SUB,0,0,0,0,0,2'b10,2'b00));   // MEM forward
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(add_i, 0, z);
    add(nop_i, 0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(sub_i, 0, z);
    add(nop_i, 0, ex(1,0,A_SUB,0,0,1,0,0,2'b01,2'b00));   // WB forward
    add(nop_i, 0, z);
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(add0_i,0, z);
    add(sub0_i,0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_SUB,0,0,0,0,0,2'b00,2'b00));   // $0 never forwards
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(lw_i,  0, z);
    add(add2_i,0, ex(0,1,A_ADD,0,0,0,0,1,2'b00,2'b00));   // load-use stall
    add(add2_i,0, z);                                     // bubble in EX
    add(nop_i, 0, ex(1,0,A_ADD,0,1,1,0,0,2'b01,2'b01));
    add(nop_i, 0, z);
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(beq_i, 0, z);
    add(add_i, 1, ex(0,0,A_SUB,0,0,0,1,0,2'b00,2'b00));   // taken branch
    add(nop_i, 0, z);
    add(nop_i, 1, z);                                     // zeroE with no branch in EX
    add(nop_i, 0, z);                                     // flushed add never writes
    add(beq_i, 0, z);
    add(nop_i, 0, ex(0,0,A_SUB,0,0,0,0,0,2'b00,2'b00));   // not taken
    add(nop_i, 0, z);
    add(sw_i,  0, z);
    add(slt_i, 0, ex(0,1,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_SLT,1,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, z);                                     // sw never writes regfile
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, z);
    add(add_i, 0, z);
    add(subb_i,0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_SUB,0,0,0,0,0,2'b00,2'b10));   // MEM forward on B
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(add_i, 0, z);
    add(addi3_i,0,ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(sub_i, 0, ex(0,1,A_ADD,0,0,0,0,0,2'b10,2'b10));
    add(nop_i, 0, ex(1,0,A_SUB,0,0,1,0,0,2'b10,2'b00));   // MEM beats WB
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
`else
    add(nop_i, 0, z);
    add(add_i, 0, z);
    add(sub_i, 0, ex(1,0,A_ADD,0,0,0,0,1,2'b00,2'b00));   // RAW on EX writer
    add(sub_i, 0, ex(0,0,A_0,  0,0,0,0,1,2'b00,2'b00));   // RAW on MEM writer
    add(sub_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));   // WB write is not a hazard
    add(nop_i, 0, ex(1,0,A_SUB,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, z);
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(add0_i,0, z);
    add(sub0_i,0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));   // $0 never stalls
    add(nop_i, 0, ex(1,0,A_SUB,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(lw_i,  0, z);
    add(beq_i, 0, ex(0,1,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(add2_i,1, ex(0,0,A_SUB,0,0,0,1,0,2'b00,2'b00));   // flush beats pending stall
    add(nop_i, 0, ex(0,0,A_0,  0,1,1,0,0,2'b00,2'b00));
    add(nop_i, 0, z);
    add(nop_i, 0, z);                                     // flushed add never writes
    add(sw_i,  0, z);
    add(slt_i, 0, ex(0,1,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_SLT,1,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, z);                                     // sw never writes regfile
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(lw_i,  0, z);
    add(add2_i,0, ex(0,1,A_ADD,0,0,0,0,1,2'b00,2'b00));
    add(add2_i,0, ex(0,0,A_0,  0,0,0,0,1,2'b00,2'b00));
    add(add2_i,0, ex(0,0,A_0,  0,1,1,0,0,2'b00,2'b00));
    add(nop_i, 0, ex(1,0,A_ADD,0,0,0,0,0,2'b00,2'b00));
    add(nop_i, 0, z);
    add(nop_i, 0, ex(0,0,A_0,  0,0,1,0,0,2'b00,2'b00));
    add(nop_i, 0, z);
`endif

    // Reset state
    @(negedge clk);
    check("reset", 0, z);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table stream
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Fill the pipe with a write, a store and a taken branch, then reset mid-cycle
    bus.zeroE  = 1'b0;
    bus.instrD = add_i;
    @(posedge clk); #1;
    bus.instrD = sw_i;
    @(posedge clk); #1;
    bus.instrD = beq_i;
    @(posedge clk); #1;
    bus.instrD = nop_i;
    bus.zeroE  = 1'b1;
    #2;
    check("inflight", 0, ex(0,0,A_SUB,1,0,1,1,0,2'b00,2'b00));
    rst = 1'b1;
    #1;
    check("rst_async", 0, z);
    @(posedge clk);
    #1;
    check("rst_held", 0, z);
    @(negedge clk);
    rst = 1'b0;
    bus.zeroE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst", i, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
